// File: rtl/clk_div_prog_pkg.sv
// Shared definitions for the programmable clock divider.
// Contents:
//   state_t   - divider run state (IDLE, RUN, STOP)
//   MIN_DIV   - smallest divisor that can be loaded
//   half_ceil - ceil(N/2), the number of posedge cycles out_p stays high
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  // Evaluated in 32 bits, so (N+1) cannot wrap for any supported WIDTH.
  function automatic int unsigned half_ceil(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle for clk_div_prog.
// Ports:
//   en       - run request
//   div_val  - new divisor, qualified by div_load
//   div_load - one-cycle load strobe
//   clk_out  - divided clock, 50 % duty
//   tick     - one-cycle pulse in the first cycle of each output period
//   running  - divider is in RUN or STOP
//   busy     - a divisor load is waiting for a period boundary
//   div_err  - one-cycle pulse when a load is rejected
//   div_cur  - divisor currently in effect
// The master modport drives the controls; the slave modport is the divider.
interface clk_div_prog_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic             running;
  logic             busy;
  logic             div_err;
  logic [WIDTH-1:0] div_cur;

  modport master (
    output en, div_val, div_load,
    input  clk_out, tick, running, busy, div_err, div_cur
  );

  modport slave (
    input  en, div_val, div_load,
    output clk_out, tick, running, busy, div_err, div_cur
  );
endinterface

// File: rtl/clk_div_prog_neg_retime.sv
// Single falling-edge flop used to delay the divider's posedge phase
// register by half a clock period.
// Ports:
//   clk_i - system clock (sampled on negedge)
//   rst_i - asynchronous active-high reset, clears q_o
//   d_i   - data in
//   q_o   - data retimed onto the falling edge
module neg_retime (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  // Falling-edge capture; the reset is asynchronous so the divided clock
  // drops immediately when the divider is reset mid-period.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o <= 1'b0;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider, 50 % duty for any divisor N >= 2.
// Even N uses the posedge phase register directly; odd N ANDs it with a
// half-period-delayed copy, so the high time is N/2 clk periods.
// A new divisor is held as pending and applied only on a period boundary
// (or on any edge while idle), so no output period is ever cut or stretched.
// Ports:
//   clk - system clock
//   rst - asynchronous active-high reset
//   bus - clk_div_prog_if slave: en/div_val/div_load in,
//         clk_out/tick/running/busy/div_err/div_cur out
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input logic           clk,
  input logic           rst,
  clk_div_prog_if.slave bus
);

  localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] divCur_q, divCur_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             busy_q, busy_d;
  logic             divErr_q, divErr_d;
  logic             outP_q, outP_d;
  logic             outN_q;
  logic [WIDTH:0]   halfNext;
  logic             boundary;
  logic             applyEdge;
  logic             loadBad;
  logic             loadOk;

  // The last cycle of a period is where the divisor and the run/stop
  // decision are allowed to change.
  assign boundary  = (state_q != IDLE) && (cnt_q == divCur_q - WIDTH'(1));
  assign applyEdge = (state_q == IDLE) || boundary;
  assign loadBad   = bus.div_load && (32'(bus.div_val) < MIN_DIV);
  assign loadOk    = bus.div_load && !loadBad;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A drop of en only takes effect at the end of the
  // current period; if en is already low on the boundary cycle we go
  // straight to IDLE instead of starting another period in STOP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.en) state_d = RUN;
      end
      RUN: begin
        if (!bus.en) state_d = boundary ? IDLE : STOP;
      end
      STOP: begin
        if (bus.en)        state_d = RUN;
        else if (boundary) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. The divisor for the coming period is chosen
  // first, and out_p is computed from that divisor, so the first cycle of
  // a new period already uses the new half-period threshold. A load seen
  // on the applying edge lands in pending and keeps busy set.
  always_comb begin
    divCur_d  = applyEdge ? pending_q : divCur_q;
    pending_d = loadOk ? bus.div_val : pending_q;
    busy_d    = loadOk ? 1'b1 : (applyEdge ? 1'b0 : busy_q);
    divErr_d  = loadBad;
    cnt_d     = (state_q == IDLE || boundary) ? '0 : cnt_q + WIDTH'(1);
    halfNext  = (WIDTH+1)'(half_ceil(32'(divCur_d)));
    outP_d    = (state_d != IDLE) && ({1'b0, cnt_d} < halfNext);
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      divCur_q  <= RESET_DIV;
      pending_q <= RESET_DIV;
      busy_q    <= 1'b0;
      divErr_q  <= 1'b0;
      outP_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      divCur_q  <= divCur_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      divErr_q  <= divErr_d;
      outP_q    <= outP_d;
    end
  end

  neg_retime uRetime (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (outP_q),
    .q_o   (outN_q)
  );

  // Outputs. For odd N the AND delays the rising edge by half a cycle,
  // trimming the high time from (N+1)/2 to N/2 periods.
  always_comb begin
    bus.running = (state_q != IDLE);
    bus.tick    = (state_q != IDLE) && (cnt_q == '0);
    bus.clk_out = divCur_q[0] ? (outP_q & outN_q) : outP_q;
    bus.busy    = busy_q;
    bus.div_err = divErr_q;
    bus.div_cur = divCur_q;
  end

endmodule
